// File: rtl/riscv_loader_pkg.sv
// Shared types and helpers for the RISC-V multi-core memory loader.
package riscv_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MEM_DMEM = 1'b0;
  localparam logic MEM_IMEM = 1'b1;

  localparam int unsigned CSUM_WIDTH = 32;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Aligned start and the whole burst inside the memory; 64-bit math so nothing truncates.
  function automatic logic cmd_in_range(input logic [63:0] addr,
                                        input logic [63:0] len,
                                        input logic [63:0] strb,
                                        input logic [63:0] size);
    return ((addr & (strb - 64'd1)) == 64'd0) && ((addr + (len * strb)) <= size);
  endfunction

endpackage

// File: rtl/riscv_loader_csum.sv
// Lane-sum accumulator for the loader checksum; only built with LOADER_CSUM_EN.
`ifdef LOADER_CSUM_EN
module riscv_loader_csum
  import riscv_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CSUM_WIDTH-1:0] o_csum
);

  localparam int unsigned LANES = DATA_WIDTH / CSUM_WIDTH;

  logic [CSUM_WIDTH-1:0] r_sum;
  logic [CSUM_WIDTH-1:0] w_lane_sum;

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_lane_sum = w_lane_sum + i_data[i*CSUM_WIDTH +: CSUM_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + w_lane_sum;
    end
  end

  assign o_csum = r_sum;

endmodule
`endif

// File: rtl/riscv_mem_loader.sv
// Multi-core imem/dmem loader: a load command plus a beat stream drive per-core DMA write ports.
// Define LOADER_CSUM_EN to add the 32-bit lane checksum output csum.
module riscv_mem_loader
  import riscv_loader_pkg::*;
#(
  parameter int unsigned CORE_COUNT      = 4,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned IMEM_SIZE_BYTES = 8192,
  parameter int unsigned DMEM_SIZE_BYTES = 32768,
  parameter int unsigned CORE_ID_WIDTH   = $clog2(CORE_COUNT)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic [CORE_ID_WIDTH-1:0]                      cmd_core,
  input  logic                                          cmd_bcast,
  input  logic                                          cmd_mem,
  input  logic [ADDR_WIDTH-1:0]                         cmd_addr,
  input  logic [ADDR_WIDTH-1:0]                         cmd_len,
  input  logic                                          cmd_release,
  input  logic [DATA_WIDTH-1:0]                         s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [CORE_COUNT-1:0]                         core_reset,
  output logic [CORE_COUNT*strb_width(DATA_WIDTH)-1:0]  ins_dma_wen,
  output logic [CORE_COUNT-1:0]                         data_dma_en,
  output logic [CORE_COUNT*strb_width(DATA_WIDTH)-1:0]  data_dma_wen,
  output logic [ADDR_WIDTH-1:0]                         dma_addr,
  output logic [DATA_WIDTH-1:0]                         dma_wr_data,
  output logic                                          done,
`ifdef LOADER_CSUM_EN
  output logic [CSUM_WIDTH-1:0]                         csum,
`endif
  output logic                                          error
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int unsigned WEN_WIDTH  = CORE_COUNT * STRB_WIDTH;

  state_t                  r_state,       w_state_nxt;
  logic                    r_cmd_ready,   w_cmd_ready_nxt;
  logic                    r_s_ready,     w_s_ready_nxt;
  logic [CORE_COUNT-1:0]   r_core_reset,  w_core_reset_nxt;
  logic [WEN_WIDTH-1:0]    r_ins_wen,     w_ins_wen_nxt;
  logic [CORE_COUNT-1:0]   r_data_en,     w_data_en_nxt;
  logic [WEN_WIDTH-1:0]    r_data_wen,    w_data_wen_nxt;
  logic [ADDR_WIDTH-1:0]   r_dma_addr,    w_dma_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_dma_wr_data, w_dma_wr_data_nxt;
  logic                    r_done,        w_done_nxt;
  logic                    r_error,       w_error_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,        w_addr_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt,         w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_len,         w_len_nxt;
  logic [CORE_COUNT-1:0]   r_tgt,         w_tgt_nxt;
  logic                    r_mem,         w_mem_nxt;
  logic                    r_release,     w_release_nxt;

  logic                    w_cmd_ok;
  logic [CORE_COUNT-1:0]   w_cmd_tgt;
  logic                    w_beat;

  assign w_cmd_ok  = cmd_in_range(64'(cmd_addr), 64'(cmd_len), 64'(STRB_WIDTH),
                                  (cmd_mem == MEM_IMEM) ? 64'(IMEM_SIZE_BYTES)
                                                        : 64'(DMEM_SIZE_BYTES));
  assign w_cmd_tgt = cmd_bcast ? '1 : (CORE_COUNT'(1) << cmd_core);
  assign w_beat    = (r_state == ST_LOAD) && r_s_ready && s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_s_ready     <= 1'b0;
      r_core_reset  <= '1;
      r_ins_wen     <= '0;
      r_data_en     <= '0;
      r_data_wen    <= '0;
      r_dma_addr    <= '0;
      r_dma_wr_data <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_len         <= '0;
      r_tgt         <= '0;
      r_mem         <= MEM_DMEM;
      r_release     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_s_ready     <= w_s_ready_nxt;
      r_core_reset  <= w_core_reset_nxt;
      r_ins_wen     <= w_ins_wen_nxt;
      r_data_en     <= w_data_en_nxt;
      r_data_wen    <= w_data_wen_nxt;
      r_dma_addr    <= w_dma_addr_nxt;
      r_dma_wr_data <= w_dma_wr_data_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_addr        <= w_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_len         <= w_len_nxt;
      r_tgt         <= w_tgt_nxt;
      r_mem         <= w_mem_nxt;
      r_release     <= w_release_nxt;
    end
  end

  // Next-state and registered-output logic; enables and done/error are single-cycle pulses.
  always_comb begin
    w_state_nxt       = r_state;
    w_core_reset_nxt  = r_core_reset;
    w_ins_wen_nxt     = '0;
    w_data_en_nxt     = '0;
    w_data_wen_nxt    = '0;
    w_dma_addr_nxt    = r_dma_addr;
    w_dma_wr_data_nxt = r_dma_wr_data;
    w_done_nxt        = 1'b0;
    w_error_nxt       = 1'b0;
    w_addr_nxt        = r_addr;
    w_cnt_nxt         = r_cnt;
    w_len_nxt         = r_len;
    w_tgt_nxt         = r_tgt;
    w_mem_nxt         = r_mem;
    w_release_nxt     = r_release;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!w_cmd_ok) begin
            w_error_nxt = 1'b1;
          end else begin
            w_tgt_nxt        = w_cmd_tgt;
            w_mem_nxt        = cmd_mem;
            w_release_nxt    = cmd_release;
            w_len_nxt        = cmd_len;
            w_addr_nxt       = cmd_addr;
            w_cnt_nxt        = '0;
            w_core_reset_nxt = r_core_reset | w_cmd_tgt;
            w_state_nxt      = (cmd_len == '0) ? ST_DONE : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_beat) begin
          w_dma_addr_nxt    = r_addr;
          w_dma_wr_data_nxt = s_data;
          w_addr_nxt        = r_addr + ADDR_WIDTH'(STRB_WIDTH);
          w_cnt_nxt         = r_cnt + ADDR_WIDTH'(1);
          for (int i = 0; i < int'(CORE_COUNT); i++) begin
            if (r_tgt[i]) begin
              if (r_mem == MEM_IMEM) begin
                w_ins_wen_nxt[i*STRB_WIDTH +: STRB_WIDTH] = '1;
              end else begin
                w_data_en_nxt[i]                           = 1'b1;
                w_data_wen_nxt[i*STRB_WIDTH +: STRB_WIDTH] = '1;
              end
            end
          end
          if (w_cnt_nxt == r_len) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
        if (r_release) begin
          w_core_reset_nxt = r_core_reset & ~r_tgt;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    w_s_ready_nxt   = (w_state_nxt == ST_LOAD);
  end

`ifdef LOADER_CSUM_EN
  logic w_csum_clear;
  assign w_csum_clear = (r_state == ST_IDLE) && cmd_valid;

  riscv_loader_csum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_csum_clear),
    .i_en    (w_beat),
    .i_data  (s_data),
    .o_csum  (csum)
  );
`endif

  assign cmd_ready    = r_cmd_ready;
  assign s_ready      = r_s_ready;
  assign core_reset   = r_core_reset;
  assign ins_dma_wen  = r_ins_wen;
  assign data_dma_en  = r_data_en;
  assign data_dma_wen = r_data_wen;
  assign dma_addr     = r_dma_addr;
  assign dma_wr_data  = r_dma_wr_data;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Self-checking bench for riscv_mem_loader: directed and random loads against a transaction-level model.
// Checks csum as well when LOADER_CSUM_EN is defined.
module tb_riscv_mem_loader;

  localparam int NC   = 4;
  localparam int SB   = 8;
  localparam int IMEM = 8192;
  localparam int DMEM = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_core;
  logic        cmd_bcast;
  logic        cmd_mem;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_release;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  core_reset;
  logic [31:0] ins_dma_wen;
  logic [3:0]  data_dma_en;
  logic [31:0] data_dma_wen;
  logic [15:0] dma_addr;
  logic [63:0] dma_wr_data;
  logic        done;
  logic        error;
`ifdef LOADER_CSUM_EN
  logic [31:0] csum;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] mdl_rst;

  riscv_mem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_core     (cmd_core),
    .cmd_bcast    (cmd_bcast),
    .cmd_mem      (cmd_mem),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_release  (cmd_release),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .core_reset   (core_reset),
    .ins_dma_wen  (ins_dma_wen),
    .data_dma_en  (data_dma_en),
    .data_dma_wen (data_dma_wen),
    .dma_addr     (dma_addr),
    .dma_wr_data  (dma_wr_data),
    .done         (done),
`ifdef LOADER_CSUM_EN
    .csum         (csum),
`endif
    .error        (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] tgt);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NC; i++) if (tgt[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ins"},  ins_dma_wen,  0);
    chk({tag, "_den"},  data_dma_en,  0);
    chk({tag, "_dwen"}, data_dma_wen, 0);
  endtask

  // One command end to end; gap_pct < 0 selects the explicit s_valid pattern pat (LSB first).
  task automatic run_cmd(input int core, input bit bc, input bit mem, input int addr, input int len,
                         input bit rel, input int mode, input logic [31:0] pat, input int gap_pct);
    logic [3:0]  tgt, held, fin;
    logic [63:0] dq[$];
    logic [63:0] w;
    int          size, sent, k, it;
    bit          err, acc;
`ifdef LOADER_CSUM_EN
    logic [31:0] exp_sum;
    exp_sum = '0;
`endif
    tgt  = bc ? 4'hF : 4'(4'b0001 << core);
    size = mem ? IMEM : DMEM;
    err  = (addr % SB != 0) || (addr + len * SB > size);
    for (int j = 0; j < len; j++) begin
      case (mode)
        1:       w = 64'(j + 1) * 64'h11;
        2:       w = 64'h0000_0001_0000_0002;
        default: w = {$urandom, $urandom};
      endcase
      dq.push_back(w);
`ifdef LOADER_CSUM_EN
      exp_sum = exp_sum + w[31:0] + w[63:32];
`endif
    end

    chk("pre_rdy", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_core    = 2'(core);
    cmd_bcast   = bc;
    cmd_mem     = mem;
    cmd_addr    = 16'(addr);
    cmd_len     = 16'(len);
    cmd_release = rel;
    s_valid     = 1'b1;
    s_data      = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    cmd_valid = 1'b0;
    s_valid   = 1'b0;

    if (err) begin
      chk("err_pulse", error, 1);
      chk_quiet("err");
      chk("err_rst", core_reset, mdl_rst);
      chk("err_rdy", cmd_ready, 1);
      chk("err_srdy", s_ready, 0);
      step();
      chk("err_clr", error, 0);
      chk_quiet("err2");
      return;
    end

    held = mdl_rst | tgt;
    fin  = rel ? (held & ~tgt) : held;
    chk("acc_err", error, 0);
    chk("acc_rst", core_reset, held);
    chk("acc_rdy", cmd_ready, 0);
    chk("acc_srdy", s_ready, (len > 0));

    sent = 0;
    k    = 0;
    it   = 0;
    while (sent < len && it < 2000) begin
      chk("load_done", done, 0);
      chk("load_srdy", s_ready, 1);
      if (gap_pct < 0) s_valid = pat[k % 32];
      else             s_valid = ($urandom_range(99) >= 32'(gap_pct));
      k++;
      s_data = s_valid ? dq[sent] : {$urandom, $urandom};
      acc    = s_valid;
      step();
      s_valid = 1'b0;
      if (acc) begin
        chk("w_ins",  ins_dma_wen,  mem ? lane_mask(tgt) : 32'd0);
        chk("w_den",  data_dma_en,  mem ? 4'd0 : tgt);
        chk("w_dwen", data_dma_wen, mem ? 32'd0 : lane_mask(tgt));
        chk("w_addr", dma_addr, 16'(addr + sent * SB));
        chk("w_data", dma_wr_data, dq[sent]);
        sent++;
      end else begin
        chk_quiet("gap");
      end
      chk("load_rst", core_reset, held);
      it++;
    end
    if (sent < len) chk("load_timeout", sent, len);

    if (len > 0) begin
      chk("last_srdy", s_ready, 0);
      chk("last_done", done, 0);
    end
    step();
    chk("done", done, 1);
    chk("done_rst", core_reset, fin);
    chk("done_rdy", cmd_ready, 1);
    chk("done_srdy", s_ready, 0);
    chk_quiet("done");
`ifdef LOADER_CSUM_EN
    chk("csum", csum, exp_sum);
`endif
    step();
    chk("done_clr", done, 0);
    mdl_rst = fin;
  endtask

  initial begin
    int r_core, r_addr, r_len, r_size;
    bit r_bc, r_mem, r_rel;

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_core    = '0;
    cmd_bcast   = 1'b0;
    cmd_mem     = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_release = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    mdl_rst     = 4'hF;
    step();
    step();
    chk("rst_core", core_reset, 4'hF);
    chk("rst_rdy", cmd_ready, 1);
    chk("rst_srdy", s_ready, 0);
    chk_quiet("rst");
    chk("rst_addr", dma_addr, 0);
    chk("rst_data", dma_wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    rst = 1'b0;
    step();

    // unicast imem, contiguous beats, release
    run_cmd(2, 0, 1, 'h0100, 4, 1, 1, 32'hFFFF_FFFF, -1);
    chk("uni_rst", core_reset, 4'b1011);
    // broadcast dmem at the top word, held in reset
    run_cmd(0, 1, 0, 'h7FF8, 1, 0, 0, 32'hFFFF_FFFF, -1);
    chk("bc_rst", core_reset, 4'b1111);
    // misaligned and overflowing commands, then the exact-fit one
    run_cmd(1, 0, 1, 'h0004, 1, 1, 0, 32'hFFFF_FFFF, -1);
    run_cmd(1, 0, 1, 'h1FF8, 2, 1, 0, 32'hFFFF_FFFF, -1);
    run_cmd(1, 0, 1, 'h1FF8, 1, 1, 0, 32'hFFFF_FFFF, -1);
    // s_valid 1,0,0,1,1 with gaps
    run_cmd(3, 0, 0, 'h0040, 3, 1, 0, 32'b11001, -1);
    // zero-length load
    run_cmd(0, 0, 0, 'h0000, 0, 1, 0, 32'hFFFF_FFFF, -1);
    // checksum pattern
    run_cmd(1, 0, 0, 'h0200, 2, 0, 2, 32'hFFFF_FFFF, -1);

    for (int n = 0; n < 24; n++) begin
      r_mem  = 1'($urandom_range(1));
      r_bc   = ($urandom_range(3) == 0);
      r_rel  = 1'($urandom_range(1));
      r_core = int'($urandom_range(NC - 1));
      r_len  = int'($urandom_range(6));
      r_size = r_mem ? IMEM : DMEM;
      r_addr = int'($urandom_range(r_size / SB - 1)) * SB;
      if ($urandom_range(5) == 0) r_addr = r_size - SB * int'($urandom_range(3));
      if ($urandom_range(9) == 0) r_addr = r_addr + 4;
      run_cmd(r_core, r_bc, r_mem, r_addr, r_len, r_rel, 0, 32'hFFFF_FFFF, 30);
    end

    // reset in the middle of a load
    cmd_valid   = 1'b1;
    cmd_core    = 2'd0;
    cmd_bcast   = 1'b0;
    cmd_mem     = 1'b1;
    cmd_addr    = 16'h0000;
    cmd_len     = 16'd4;
    cmd_release = 1'b1;
    step();
    cmd_valid = 1'b0;
    s_valid   = 1'b1;
    s_data    = 64'hA5A5_0000_0000_0001;
    step();
    s_data    = 64'hA5A5_0000_0000_0002;
    step();
    s_valid   = 1'b0;
    chk("rl_wr", ins_dma_wen, 32'h0000_00FF);
    chk("rl_addr", dma_addr, 16'h0008);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_core", core_reset, 4'hF);
    chk("rl_rdy", cmd_ready, 1);
    chk("rl_srdy", s_ready, 0);
    chk_quiet("rl");
    chk("rl_daddr", dma_addr, 0);
    chk("rl_ddata", dma_wr_data, 0);
    chk("rl_done", done, 0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("rl_nodone", done, 0);
    end
    mdl_rst = 4'hF;
    run_cmd(3, 0, 1, 'h0010, 2, 1, 0, 32'hFFFF_FFFF, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_loader.md
Name: riscv_mem_loader

Overview:
Parametrised multi-core instruction/data memory loader for the RISC-V core array. Accepts a load command plus a valid/ready data stream and drives the per-core ins_dma/data_dma write ports on a shared address/data bus with per-core byte enables. Supports unicast or broadcast to all cores and manages each core's core_reset around the load. Replaces per-core hand-driven DMA pokes from the host interface.

Parameters:
CORE_COUNT, 4, number of cores served
DATA_WIDTH, 64, DMA word width; STRB_WIDTH = DATA_WIDTH/8
ADDR_WIDTH, 16, byte address width of DMA ports
IMEM_SIZE_BYTES, 8192, instruction memory size per core
DMEM_SIZE_BYTES, 32768, data memory size per core
CORE_ID_WIDTH, $clog2(CORE_COUNT), core select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_core  in  CORE_ID_WIDTH  target core
cmd_bcast  in  1  1 = all cores, cmd_core ignored
cmd_mem  in  1  0 = dmem, 1 = imem
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  ADDR_WIDTH  beat count
cmd_release  in  1  release core_reset at end of load
s_data  in  DATA_WIDTH  payload word
s_valid  in  1  payload valid
s_ready  out  1  payload ready
core_reset  out  CORE_COUNT  per-core reset
ins_dma_wen  out  CORE_COUNT*STRB_WIDTH  per-core imem byte enables
data_dma_en  out  CORE_COUNT  per-core dmem enable
data_dma_wen  out  CORE_COUNT*STRB_WIDTH  per-core dmem byte enables
dma_addr  out  ADDR_WIDTH  shared write byte address
dma_wr_data  out  DATA_WIDTH  shared write data
done  out  1  one-cycle pulse, command finished
error  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset: core_reset all ones; all wen/en 0; dma_addr, dma_wr_data 0; cmd_ready 1; s_ready, done, error 0; state IDLE.
- States IDLE, LOAD, DONE.
- IDLE: cmd_ready=1, s_ready=0. On accept, latch fields. Error checks in same cycle: cmd_addr not multiple of STRB_WIDTH, or cmd_addr + cmd_len*STRB_WIDTH > selected memory size (compute at ADDR_WIDTH+CORE-safe width, no truncation) -> error pulse next cycle, stay IDLE, no writes, core_reset unchanged.
- Valid command: next cycle core_reset bit(s) of target set to 1; go LOAD (or DONE directly if cmd_len=0).
- LOAD: cmd_ready=0, s_ready=1. Each s_valid&s_ready beat -> registered write next cycle: dma_addr = current address, dma_wr_data = s_data, target enables all ones (ins_dma_wen if imem, data_dma_en+data_dma_wen if dmem) for exactly one cycle; address += STRB_WIDTH. Enables 0 in cycles with no beat. s_valid gaps allowed. After beat cmd_len accepted, s_ready drops next cycle, go DONE.
- DONE: one cycle; done=1; if cmd_release, clear target core_reset bit(s); else leave held. Return to IDLE (cmd_ready=1 following cycle).
- Throughput: 1 beat/cycle; last write precedes done by one cycle.
- Cores not targeted: enables and core_reset untouched throughout.
- rst mid-LOAD: abort immediately, reset values, partial writes not reverted; no done.
- s_valid while IDLE: ignored (s_ready=0).

Optional Feature:
LOADER_CSUM_EN: adds output csum (32 bits), sum mod 2^32 of all 32-bit lanes of every written word in the command, cleared on command accept, valid while done=1. Without macro: port absent, no adder logic.

Decomposition:
- Package riscv_loader_pkg: state enum (IDLE/LOAD/DONE), MEM_DMEM=0/MEM_IMEM=1 encoding, STRB_WIDTH derivation function, size-check function.
- One sub-module natural when feature enabled: riscv_loader_csum (lane adder accumulator); otherwise single module.

Test Plan:
- Unicast imem: core 2, addr 0x0100, len 4, release=1, beats 0x11..0x44 -> writes at 0x100/108/110/118 on ins_dma_wen[2*8+:8]=0xFF only; done 1 cycle after last write; core_reset 4'b1111 -> 4'b1011.
- Broadcast dmem, addr 0x7FF8, len 1, release=0 -> all 4 data_dma_en=1 at 0x7FF8; done; core_reset stays 4'b1111.
- Misaligned addr 0x0004 -> error pulse, no enables asserted, cmd_ready back to 1 next cycle.
- Overflow: imem addr 0x1FF8, len 2 -> error; imem addr 0x1FF8, len 1 -> accepted, one write.
- s_valid toggling 1,0,0,1,1 with len 3 -> three writes, enables low in gap cycles, addresses contiguous.
- rst asserted after 2 of 4 beats -> outputs at reset values next cycle, core_reset 4'b1111, no done; LOADER_CSUM_EN run of 0x0000000100000002 x2 -> csum=6.
